// File: rtl/mem_port_arbiter.sv
// Arbitrates one 16-bit synchronous memory port between instruction fetch and
// data access; data wins. Build option: MEM_ARB_ALIGN_CHK_EN enables misalignment errors.
module mem_port_arbiter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_valid_o,
  output logic [15:0] if_rdata_o,
  output logic        fetch_stall_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic        dm_size_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic        dm_done_o,
  output logic [31:0] dm_rdata_o,
  output logic        dm_err_o,
  output logic        dm_stall_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_re_o,
  output logic        mem_we_o,
  output logic [15:0] mem_wdata_o,
  input  logic [15:0] mem_rdata_i,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_D_HI   = 2'd1,
    ST_D_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] low_q;
  logic        err_q;
  logic        if_valid_q;
  logic        misaligned;
  logic        dm_start;

`ifdef MEM_ARB_ALIGN_CHK_EN
  assign misaligned = dm_size_i ? (dm_addr_i[1:0] != 2'b00) : dm_addr_i[0];
`else
  assign misaligned = 1'b0;
`endif

  // A misaligned request never touches the port, so it does not block fetch.
  assign dm_start    = (state_q == ST_IDLE) && dm_req_i && !misaligned;
  assign dbg_state_o = state_q;

  always_comb begin
    if_gnt_o      = 1'b0;
    if_valid_o    = 1'b0;
    if_rdata_o    = 16'h0;
    fetch_stall_o = 1'b0;
    dm_done_o     = 1'b0;
    dm_rdata_o    = 32'h0;
    dm_err_o      = 1'b0;
    dm_stall_o    = 1'b0;
    mem_addr_o    = 32'h0;
    mem_re_o      = 1'b0;
    mem_we_o      = 1'b0;
    mem_wdata_o   = 16'h0;
    // Reset forces every output low in the same cycle.
    if (!rst_i) begin
      case (state_q)
        ST_IDLE: begin
          if (dm_start) begin
            mem_addr_o  = dm_addr_i;
            mem_re_o    = !dm_we_i;
            mem_we_o    = dm_we_i;
            mem_wdata_o = dm_we_i ? dm_wdata_i[15:0] : 16'h0;
          end
        end
        ST_D_HI: begin
          mem_addr_o  = dm_addr_i + 32'd2;
          mem_re_o    = !dm_we_i;
          mem_we_o    = dm_we_i;
          mem_wdata_o = dm_we_i ? dm_wdata_i[31:16] : 16'h0;
        end
        ST_D_DONE: begin
          dm_done_o = 1'b1;
`ifdef MEM_ARB_ALIGN_CHK_EN
          dm_err_o  = err_q;
`endif
          if (err_q || dm_we_i) dm_rdata_o = 32'h0;
          else if (dm_size_i)   dm_rdata_o = {mem_rdata_i, low_q};
          else                  dm_rdata_o = {16'h0, mem_rdata_i};
        end
        default: ;
      endcase

      if_gnt_o = if_req_i &&
                 (((state_q == ST_IDLE) && !dm_start) || (state_q == ST_D_DONE));
      if (if_gnt_o) begin
        mem_addr_o = if_addr_i;
        mem_re_o   = 1'b1;
      end

      fetch_stall_o = if_req_i && !if_gnt_o;
      dm_stall_o    = dm_req_i && !dm_done_o;
      if_valid_o    = if_valid_q;
      if_rdata_o    = if_valid_q ? mem_rdata_i : 16'h0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      low_q      <= 16'h0;
      err_q      <= 1'b0;
      if_valid_q <= 1'b0;
    end else begin
      if_valid_q <= if_gnt_o;
      case (state_q)
        ST_IDLE: begin
          if (dm_req_i) begin
            err_q   <= misaligned;
            state_q <= (misaligned || !dm_size_i) ? ST_D_DONE : ST_D_HI;
          end
        end
        ST_D_HI: begin
          if (!dm_we_i) low_q <= mem_rdata_i;
          state_q <= ST_D_DONE;
        end
        ST_D_DONE: begin
          err_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous memory model
// behind the port and hand-computed expectations.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [15:0] if_rdata;
  logic        fetch_stall;
  logic        dm_req;
  logic        dm_we;
  logic        dm_size;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_done;
  logic [31:0] dm_rdata;
  logic        dm_err;
  logic        dm_stall;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // Memory model: halfword array indexed by address bits [9:1], plus a backdoor preload.
  logic [15:0] mem [0:511];
  logic        pre_we;
  logic [8:0]  pre_idx;
  logic [15:0] pre_d;

  mem_port_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .if_req_i     (if_req),
    .if_addr_i    (if_addr),
    .if_gnt_o     (if_gnt),
    .if_valid_o   (if_valid),
    .if_rdata_o   (if_rdata),
    .fetch_stall_o(fetch_stall),
    .dm_req_i     (dm_req),
    .dm_we_i      (dm_we),
    .dm_size_i    (dm_size),
    .dm_addr_i    (dm_addr),
    .dm_wdata_i   (dm_wdata),
    .dm_done_o    (dm_done),
    .dm_rdata_o   (dm_rdata),
    .dm_err_o     (dm_err),
    .dm_stall_o   (dm_stall),
    .mem_addr_o   (mem_addr),
    .mem_re_o     (mem_re),
    .mem_we_o     (mem_we),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .dbg_state_o  (dbg_state)
  );

  // Clock and memory
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_d;
    else if (mem_we) mem[mem_addr[9:1]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr[9:1]];
  end

  // Driver helpers
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic preload(input logic [31:0] a, input logic [15:0] d);
    pre_we  = 1'b1;
    pre_idx = a[9:1];
    pre_d   = d;
    cyc();
    pre_we  = 1'b0;
  endtask

  task automatic dm_set(input logic req, input logic we, input logic size,
                        input logic [31:0] a, input logic [31:0] wd);
    dm_req   = req;
    dm_we    = we;
    dm_size  = size;
    dm_addr  = a;
    dm_wdata = wd;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0;
    pre_we = 1'b0; pre_idx = 9'h0; pre_d = 16'h0;
    dm_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(); cyc();

    // Requests during reset: every output must stay low.
    if_req = 1'b1; if_addr = 32'h10;
    dm_set(1'b1, 1'b0, 1'b1, 32'h100, 32'h0);
    mid();
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_fetch_stall", fetch_stall, 0);
    chk("rst_dm_stall", dm_stall, 0);
    chk("rst_dm_done", dm_done, 0);
    chk("rst_state", dbg_state, 0);
    cyc();
    if_req = 1'b0;
    dm_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    preload(32'h0, 16'hA001);
    preload(32'h2, 16'hA002);
    preload(32'h4, 16'hA003);
    preload(32'h100, 16'h5678);
    preload(32'h102, 16'h1234);
    preload(32'h200, 16'h0000);
    preload(32'h202, 16'h7777);
    preload(32'h300, 16'h0000);
    preload(32'h302, 16'h5555);
    rst = 1'b0;
    cyc();

    // Fetch only: one halfword per cycle, data one cycle after grant.
    if_req = 1'b1; if_addr = 32'h0;
    mid();
    chk("f0_gnt", if_gnt, 1);
    chk("f0_addr", mem_addr, 32'h0);
    chk("f0_re", mem_re, 1);
    chk("f0_valid", if_valid, 0);
    chk("f0_stall", fetch_stall, 0);
    cyc();
    if_addr = 32'h2;
    mid();
    chk("f1_gnt", if_gnt, 1);
    chk("f1_addr", mem_addr, 32'h2);
    chk("f1_valid", if_valid, 1);
    chk("f1_rdata", if_rdata, 16'hA001);
    cyc();
    if_addr = 32'h4;
    mid();
    chk("f2_gnt", if_gnt, 1);
    chk("f2_rdata", if_rdata, 16'hA002);
    cyc();
    if_req = 1'b0;
    mid();
    chk("f3_gnt", if_gnt, 0);
    chk("f3_valid", if_valid, 1);
    chk("f3_rdata", if_rdata, 16'hA003);
    chk("f3_idle_addr", mem_addr, 32'h0);
    chk("f3_idle_re", mem_re, 0);
    cyc();
    mid();
    chk("f4_valid", if_valid, 0);
    cyc();

    // Word read at 0x100 with a concurrent fetch of 0x4.
    if_req = 1'b1; if_addr = 32'h4;
    dm_set(1'b1, 1'b0, 1'b1, 32'h100, 32'h0);
    mid();
    chk("wr0_addr", mem_addr, 32'h100);
    chk("wr0_re", mem_re, 1);
    chk("wr0_gnt", if_gnt, 0);
    chk("wr0_fstall", fetch_stall, 1);
    chk("wr0_dstall", dm_stall, 1);
    chk("wr0_done", dm_done, 0);
    cyc();
    mid();
    chk("wr1_addr", mem_addr, 32'h102);
    chk("wr1_re", mem_re, 1);
    chk("wr1_fstall", fetch_stall, 1);
    chk("wr1_state", dbg_state, 1);
    chk("wr1_done", dm_done, 0);
    cyc();
    mid();
    chk("wr2_done", dm_done, 1);
    chk("wr2_rdata", dm_rdata, 32'h12345678);
    chk("wr2_err", dm_err, 0);
    chk("wr2_gnt", if_gnt, 1);
    chk("wr2_addr", mem_addr, 32'h4);
    chk("wr2_fstall", fetch_stall, 0);
    chk("wr2_dstall", dm_stall, 0);
    cyc();
    if_req = 1'b0;
    dm_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    mid();
    chk("wr3_valid", if_valid, 1);
    chk("wr3_rdata", if_rdata, 16'hA003);
    chk("wr3_done", dm_done, 0);
    chk("wr3_dm_rdata", dm_rdata, 32'h0);
    cyc();

    // Halfword write of 0xBEEF to 0x200.
    dm_set(1'b1, 1'b1, 1'b0, 32'h200, 32'h1111BEEF);
    mid();
    chk("hw0_we", mem_we, 1);
    chk("hw0_re", mem_re, 0);
    chk("hw0_addr", mem_addr, 32'h200);
    chk("hw0_wdata", mem_wdata, 16'hBEEF);
    chk("hw0_done", dm_done, 0);
    cyc();
    mid();
    chk("hw1_done", dm_done, 1);
    chk("hw1_we", mem_we, 0);
    chk("hw1_rdata", dm_rdata, 32'h0);
    cyc();
    dm_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    mid();
    chk("hw_mem_lo", mem[9'h100], 16'hBEEF);
    chk("hw_mem_hi", mem[9'h101], 16'h7777);
    cyc();

    // Word write of 0xCAFEF00D to 0xFFFFFFFC.
    dm_set(1'b1, 1'b1, 1'b1, 32'hFFFFFFFC, 32'hCAFEF00D);
    mid();
    chk("ww0_addr", mem_addr, 32'hFFFFFFFC);
    chk("ww0_wdata", mem_wdata, 16'hF00D);
    chk("ww0_we", mem_we, 1);
    cyc();
    mid();
    chk("ww1_addr", mem_addr, 32'hFFFFFFFE);
    chk("ww1_wdata", mem_wdata, 16'hCAFE);
    chk("ww1_we", mem_we, 1);
    cyc();
    mid();
    chk("ww2_done", dm_done, 1);
    chk("ww2_we", mem_we, 0);
    cyc();
    dm_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    mid();
    chk("ww_mem_lo", mem[9'h1FE], 16'hF00D);
    chk("ww_mem_hi", mem[9'h1FF], 16'hCAFE);
    cyc();

`ifndef MEM_ARB_ALIGN_CHK_EN
    // Word read at 0xFFFFFFFE: high beat wraps to 0x0.
    dm_set(1'b1, 1'b0, 1'b1, 32'hFFFFFFFE, 32'h0);
    mid();
    chk("wrap0_addr", mem_addr, 32'hFFFFFFFE);
    cyc();
    mid();
    chk("wrap1_addr", mem_addr, 32'h0);
    chk("wrap1_re", mem_re, 1);
    cyc();
    mid();
    chk("wrap2_done", dm_done, 1);
    chk("wrap2_rdata", dm_rdata, 32'hA001CAFE);
    chk("wrap2_err", dm_err, 0);
    cyc();
    dm_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc();
`else
    // Misaligned word read at 0x102: no data beat, error done, fetch granted throughout.
    if_req = 1'b1; if_addr = 32'h6;
    dm_set(1'b1, 1'b0, 1'b1, 32'h102, 32'h0);
    mid();
    chk("mis0_gnt", if_gnt, 1);
    chk("mis0_addr", mem_addr, 32'h6);
    chk("mis0_done", dm_done, 0);
    chk("mis0_dstall", dm_stall, 1);
    cyc();
    mid();
    chk("mis1_done", dm_done, 1);
    chk("mis1_err", dm_err, 1);
    chk("mis1_rdata", dm_rdata, 32'h0);
    chk("mis1_gnt", if_gnt, 1);
    chk("mis1_addr", mem_addr, 32'h6);
    cyc();
    if_req = 1'b0;
    dm_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    mid();
    chk("mis2_err", dm_err, 0);
    cyc();
`endif

    // Reset during the high beat of a word write to 0x300.
    dm_set(1'b1, 1'b1, 1'b1, 32'h300, 32'h99998888);
    mid();
    chk("rw0_we", mem_we, 1);
    chk("rw0_wdata", mem_wdata, 16'h8888);
    cyc();
    rst = 1'b1;
    mid();
    chk("rw1_we", mem_we, 0);
    chk("rw1_re", mem_re, 0);
    chk("rw1_done", dm_done, 0);
    chk("rw1_dstall", dm_stall, 0);
    cyc();
    rst = 1'b0;
    dm_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    mid();
    chk("rw2_state", dbg_state, 0);
    chk("rw2_mem_lo", mem[9'h180], 16'h8888);
    chk("rw2_mem_hi", mem[9'h181], 16'h5555);
    for (int i = 0; i < 3; i++) begin
      chk("rw_no_done", dm_done, 0);
      cyc();
      mid();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single 16-bit synchronous memory port between the instruction fetch requester and the load/store (data) requester. Data accesses have priority. A 32-bit data access is sequenced as two 16-bit beats: low half at A, high half at A+2, little-endian. The block produces the fetch stall used by the fetch stage and the data stall used by the memory stage. It sits between the pipeline stages and the memory macro.

## Interface
Parameters:
- none (address width 32, port width 16 fixed)

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  reset, synchronous, active-high
- if_req_i  in  1  fetch request (level)
- if_addr_i  in  32  fetch halfword address
- if_gnt_o  out  1  fetch address issued to memory this cycle
- if_valid_o  out  1  fetch data valid (cycle after grant)
- if_rdata_o  out  16  fetched halfword
- fetch_stall_o  out  1  if_req_i & ~if_gnt_o
- dm_req_i  in  1  data request; held stable with dm_we_i/size/addr/wdata until dm_done_o
- dm_we_i  in  1  1 = write, 0 = read
- dm_size_i  in  1  0 = halfword, 1 = word
- dm_addr_i  in  32  data byte address
- dm_wdata_i  in  32  write data; halfword writes use [15:0]
- dm_done_o  out  1  data access complete (single-cycle pulse)
- dm_rdata_o  out  32  read data, valid with dm_done_o, else 0
- dm_err_o  out  1  misalignment error, valid with dm_done_o
- dm_stall_o  out  1  dm_req_i & ~dm_done_o
- mem_addr_o  out  32  memory address
- mem_re_o  out  1  memory read enable
- mem_we_o  out  1  memory write enable
- mem_wdata_o  out  16  memory write data
- mem_rdata_i  in  16  memory read data; valid the cycle after mem_re_o

## Operation
- States: ST_IDLE, ST_D_HI, ST_D_DONE.
- ST_IDLE with dm_req_i, aligned:
  - Issue the low beat: mem_addr_o=dm_addr_i. A read drives mem_re_o=1. A write drives mem_we_o=1 with mem_wdata_o=dm_wdata_i[15:0].
  - Next state: ST_D_HI for a word access, ST_D_DONE for a halfword access.
- ST_D_HI:
  - Latch mem_rdata_i into low_reg (reads only).
  - Issue the high beat at dm_addr_i+2. A write drives mem_wdata_o=dm_wdata_i[31:16].
  - Next state: ST_D_DONE.
- ST_D_DONE:
  - dm_done_o=1.
  - Word read: dm_rdata_o={mem_rdata_i, low_reg}.
  - Halfword read: dm_rdata_o={16'h0, mem_rdata_i}.
  - Writes: dm_rdata_o=0.
  - Next state: ST_IDLE.
- Fetch grant: if_gnt_o=if_req_i when (ST_IDLE and no aligned dm_req_i) or ST_D_DONE.
  - On grant: mem_addr_o=if_addr_i, mem_re_o=1.
  - if_valid_o is registered: asserted the cycle after the grant, with if_rdata_o=mem_rdata_i.
- Idle port (no grant, no data beat): mem_addr_o=0, mem_re_o=mem_we_o=0, mem_wdata_o=0.
- Address arithmetic: dm_addr_i+2 is modulo 2^32; 0xFFFFFFFE wraps to 0x00000000.
- A new dm_req_i seen in ST_IDLE starts a new access. A request held high past dm_done_o is therefore re-executed; the requester deasserts it in the cycle after done.

## Timing
- Latency, request to dm_done_o: halfword 1 cycle, word 2 cycles.
- Fetch: grant cycle N, data cycle N+1. Back-to-back fetches give 1 halfword per cycle.
- Fetch blocked by data access: a halfword access blocks 1 cycle, a word access 2 cycles. The fetch is granted in the ST_D_DONE cycle.
- Reset:
  - While rst_i=1, every output is 0 in the same cycle: grants, mem enables, stalls and done. State goes to ST_IDLE, and low_reg, if_valid_o and the error flag are cleared.
  - Reset mid-access abandons the access. A word write interrupted after its low beat leaves only the low half written; this is accepted.
- The same-cycle simultaneous dm_req_i and if_req_i case is defined in the test plan (data wins).

## Configuration
- MEM_ARB_ALIGN_CHK_EN defined:
  - Misaligned data requests are detected: a word with dm_addr_i[1:0]!=0, or a halfword with dm_addr_i[0]=1.
  - Such a request issues no memory beat and goes ST_IDLE→ST_D_DONE.
  - In ST_D_DONE: dm_done_o=1, dm_err_o=1, dm_rdata_o=0.
  - The port is free in both of those cycles, so fetch may be granted in both.
- Undefined:
  - No checking; dm_err_o is tied 0.
  - Addresses pass through unmodified.

## Test plan
- Fetch only: if_req_i=1, addresses 0x0, 0x2, 0x4, memory holding 0xA001, 0xA002, 0xA003 → if_gnt_o=1 every cycle, if_valid_o one cycle later with the same data in order, fetch_stall_o=0.
- Word read at 0x100 with concurrent fetch: mem[0x100]=0x5678, mem[0x102]=0x1234 → mem addresses 0x100, 0x102, then the fetch address. dm_done_o on cycle 2 with dm_rdata_o=0x12345678. fetch_stall_o=1 for exactly 2 cycles.
- Halfword write: 0xBEEF to 0x200 → one mem_we_o beat at 0x200 with data 0xBEEF. dm_done_o the next cycle; mem[0x202] unchanged.
- Word write: 0xCAFEF00D to 0xFFFFFFFC → beats 0xFFFFFFFC/0xF00D and 0xFFFFFFFE/0xCAFE. A word access at 0xFFFFFFFE (with MEM_ARB_ALIGN_CHK_EN undefined) wraps its high beat to 0x0.
- Reset asserted in ST_D_HI of a word write → same cycle all enables 0. Next cycle ST_IDLE, only the low half written, and no dm_done_o ever pulses for the abandoned access.
- With MEM_ARB_ALIGN_CHK_EN: word read at 0x102 → no mem_re_o for data, dm_done_o=dm_err_o=1 one cycle later, and the pending fetch is granted in both cycles.
